apb_arbiter: RTL and testbench

- Two-requester APB master arbiter that shares the single 16-bit APB memory bus between instruction fetch (requester 0) and the ALU load/store unit (requester 1).
- Accepts simple req/done transactions from each requester and runs the APB SETUP/ACCESS sequence on the shared bus.
- Returns read data and a one-cycle done pulse to the granted requester.
- Sits between the CPU core and the APB memory slave.

---
 rtl/apb_arb_pkg.sv | 6 +
 rtl/arb_rr2.sv | 22 ++
 rtl/apb_arbiter.sv | 144 ++++++++++++++
 tb/tb_apb_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared state encoding, requester id type and watchdog read data for apb_arbiter.
package apb_arb_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
   typedef logic req_id_t;
   localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way grant function with a last-granted pointer for round-robin fairness.
module arb_rr2
   import apb_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       rr_en,
   output req_id_t    gnt,
   output logic       vld
);
   req_id_t last_q, last_d;
   assign vld = |req;
   assign gnt = (req == 2'b11) ? (rr_en ? ~last_q : 1'b0) : req[1];
   always_comb last_d = (update && vld) ? gnt : last_q;
   // Pointer resets to "requester 1 went last" so requester 0 wins first contention.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) last_q <= 1'b1;
      else          last_q <= last_d;
   end
endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: two-requester APB master running SETUP/ACCESS on one shared bus.
// Defining APB_TIMEOUT_EN adds an ACCESS-phase watchdog that aborts with err and 16'hDEAD.
module apb_arbiter
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter bit RR_EN          = 1'b1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_done,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_done,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   output logic              grant_id
);
   apb_state_t             state_q, state_d;
   logic [ADDR_W-1:0]      paddr_q, paddr_d;
   logic [DATA_W-1:0]      pwdata_q, pwdata_d;
   logic                   pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
   req_id_t                grant_q, grant_d, gnt;
   logic                   gnt_vld, timeout;
   logic [1:0]             done_q, done_d, err_q, err_d;
   logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

   // A requester still showing its done pulse holds a stale req and must not re-win.
   arb_rr2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     ({m1_req & ~done_q[1], m0_req & ~done_q[0]}),
      .update  (state_q == IDLE),
      .rr_en   (RR_EN),
      .gnt     (gnt),
      .vld     (gnt_vld)
   );

`ifdef APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   assign timeout = (state_q == ACCESS) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   always_comb cnt_d = (state_q == SETUP) ? '0 : (state_q == ACCESS && !pready) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   // Watchdog absent: the comparison is constant false, so ACCESS waits forever.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      grant_d   = grant_q;
      rdata_d   = rdata_q;
      done_d    = '0;
      err_d     = '0;
      case (state_q)
         IDLE: if (gnt_vld) begin
            paddr_d  = gnt ? m1_addr : m0_addr;
            pwdata_d = gnt ? m1_wdata : m0_wdata;
            pwrite_d = gnt ? m1_write : m0_write;
            grant_d  = gnt;
            psel_d   = 1'b1;
            state_d  = SETUP;
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: if (pready || timeout) begin
            psel_d          = 1'b0;
            penable_d       = 1'b0;
            state_d         = IDLE;
            done_d[grant_q] = 1'b1;
            err_d[grant_q]  = timeout;
            if (!pwrite_q) rdata_d[grant_q] = timeout ? DATA_W'(TIMEOUT_DATA) : prdata;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         grant_q   <= 1'b0;
         done_q    <= '0;
         err_q     <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign psel     = psel_q;
   assign penable  = penable_q;
   assign pwrite   = pwrite_q;
   assign paddr    = paddr_q;
   assign pwdata   = pwdata_q;
   assign grant_id = grant_q;
   assign m0_done  = done_q[0];
   assign m1_done  = done_q[1];
   assign m0_err   = err_q[0];
   assign m1_err   = err_q[1];
   assign m0_rdata = rdata_q[0];
   assign m1_rdata = rdata_q[1];
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: directed checks of apb_arbiter, with a round-robin and a fixed-priority instance.
module tb_apb_arbiter;
   logic        clk = 1'b0, reset_n = 1'b0, reset_n_fp = 1'b0;
   logic        m0_req = 1'b0, m0_write = 1'b0, m1_req = 1'b0, m1_write = 1'b0, pready = 1'b0;
   logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, prdata = '0;
   logic        m0_done, m0_err, m1_done, m1_err, psel, penable, pwrite, grant_id;
   logic [15:0] m0_rdata, m1_rdata, paddr, pwdata;
   logic        f_m0_done, f_m0_err, f_m1_done, f_m1_err, f_psel, f_penable, f_pwrite, f_grant_id;
   logic [15:0] f_m0_rdata, f_m1_rdata, f_paddr, f_pwdata;
   int          nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   apb_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
      .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
      .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .grant_id(grant_id)
   );

   apb_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .reset_n(reset_n_fp),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
      .m0_done(f_m0_done), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
      .m1_done(f_m1_done), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
      .psel(f_psel), .penable(f_penable), .pwrite(f_pwrite), .paddr(f_paddr), .pwdata(f_pwdata),
      .prdata(prdata), .pready(pready), .grant_id(f_grant_id)
   );

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      step(2);
      nvec++; if ({psel, penable, pwrite, m0_done, m1_done, m0_err, m1_err, grant_id} !== 8'h00) begin nerr++; $display("FAIL reset_ctrl: got %b want 00000000", {psel, penable, pwrite, m0_done, m1_done, m0_err, m1_err, grant_id}); end
      nvec++; if ({paddr, pwdata, m0_rdata, m1_rdata} !== 64'h0) begin nerr++; $display("FAIL reset_data: got %h want 0", {paddr, pwdata, m0_rdata, m1_rdata}); end
      nvec++; if ({f_psel, f_m0_done, f_m1_done, f_grant_id} !== 4'h0) begin nerr++; $display("FAIL reset_fp: got %b want 0000", {f_psel, f_m0_done, f_m1_done, f_grant_id}); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_reset_mid_access;
      m0_req = 1'b1; m0_addr = 16'h0010; m0_write = 1'b0; pready = 1'b0;
      step();
      nvec++; if (psel !== 1'b1) begin nerr++; $display("FAIL rst_mid_setup psel: got %b want 1", psel); end
      step();
      nvec++; if (penable !== 1'b1) begin nerr++; $display("FAIL rst_mid_access penable: got %b want 1", penable); end
      step(2);
      #2 reset_n = 1'b0;
      #1;
      nvec++; if ({psel, penable} !== 2'b00) begin nerr++; $display("FAIL rst_mid_abort: got psel/penable %b want 00", {psel, penable}); end
      m0_req = 1'b0;
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         nvec++; if ({m0_done, psel} !== 2'b00) begin nerr++; $display("FAIL rst_mid_quiet[%0d]: got done/psel %b want 00", i, {m0_done, psel}); end
      end
   endtask

   task automatic test_single_read;
      m0_req = 1'b1; m0_addr = 16'h0010; m0_write = 1'b0; pready = 1'b1; prdata = 16'h1234;
      step();
      nvec++; if ({psel, penable, pwrite, grant_id, paddr} !== {4'b1000, 16'h0010}) begin nerr++; $display("FAIL read_setup: got %b %h want 1000 0010", {psel, penable, pwrite, grant_id}, paddr); end
      step();
      nvec++; if ({psel, penable, m0_done} !== 3'b110) begin nerr++; $display("FAIL read_access: got %b want 110", {psel, penable, m0_done}); end
      step();
      nvec++; if ({m0_done, m0_err, m1_done, psel, penable} !== 5'b10000) begin nerr++; $display("FAIL read_done: got %b want 10000", {m0_done, m0_err, m1_done, psel, penable}); end
      nvec++; if (m0_rdata !== 16'h1234) begin nerr++; $display("FAIL read_rdata: got %h want 1234", m0_rdata); end
      m0_req = 1'b0;
      step();
      nvec++; if ({m0_done, psel} !== 2'b00) begin nerr++; $display("FAIL read_after: got %b want 00", {m0_done, psel}); end
   endtask

   task automatic test_write_wait;
      m1_req = 1'b1; m1_addr = 16'h0042; m1_write = 1'b1; m1_wdata = 16'hBEEF; pready = 1'b0; prdata = 16'h5555;
      step();
      nvec++; if ({psel, penable, pwrite, grant_id, paddr, pwdata} !== {4'b1011, 16'h0042, 16'hBEEF}) begin nerr++; $display("FAIL write_setup: got %b %h %h want 1011 0042 beef", {psel, penable, pwrite, grant_id}, paddr, pwdata); end
      step();
      for (int i = 0; i < 3; i++) begin
         nvec++; if ({psel, penable, pwrite, m1_done, pwdata} !== {4'b1110, 16'hBEEF}) begin nerr++; $display("FAIL write_wait[%0d]: got %b %h want 1110 beef", i, {psel, penable, pwrite, m1_done}, pwdata); end
         step();
      end
      nvec++; if ({psel, penable, m1_done} !== 3'b110) begin nerr++; $display("FAIL write_hold: got %b want 110", {psel, penable, m1_done}); end
      pready = 1'b1;
      step();
      nvec++; if ({m1_done, m1_err, m0_done, psel} !== 4'b1000) begin nerr++; $display("FAIL write_done: got %b want 1000", {m1_done, m1_err, m0_done, psel}); end
      nvec++; if ({m1_rdata, m0_rdata} !== {16'h0000, 16'h1234}) begin nerr++; $display("FAIL write_rdata_kept: got %h %h want 0000 1234", m1_rdata, m0_rdata); end
      m1_req = 1'b0; m1_write = 1'b0;
      step();
      nvec++; if (m1_done !== 1'b0) begin nerr++; $display("FAIL write_one_pulse: got %b want 0", m1_done); end
   endtask

   task automatic test_rr_contention;
      logic exp;
      m0_addr = 16'h0100; m1_addr = 16'h0200; m0_write = 1'b0; m1_write = 1'b0;
      pready = 1'b1; prdata = 16'hA5A5; m0_req = 1'b1; m1_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp = (k % 2) == 1;
         step();
         nvec++; if ({psel, penable, grant_id, paddr} !== {2'b10, exp, exp ? 16'h0200 : 16'h0100}) begin nerr++; $display("FAIL rr_grant[%0d]: got %b %h want grant %b", k, {psel, penable, grant_id}, paddr, exp); end
         step();
         nvec++; if ({psel, penable} !== 2'b11) begin nerr++; $display("FAIL rr_access[%0d]: got %b want 11", k, {psel, penable}); end
         step();
         nvec++; if ({m1_done, m0_done, psel} !== {exp, ~exp, 1'b0}) begin nerr++; $display("FAIL rr_done[%0d]: got %b want %b", k, {m1_done, m0_done, psel}, {exp, ~exp, 1'b0}); end
      end
      nvec++; if ({m0_rdata, m1_rdata} !== {16'hA5A5, 16'hA5A5}) begin nerr++; $display("FAIL rr_rdata: got %h %h want a5a5 a5a5", m0_rdata, m1_rdata); end
      m0_req = 1'b0; m1_req = 1'b0;
      step();
   endtask

   task automatic test_fixed_priority;
      reset_n = 1'b0; reset_n_fp = 1'b0;
      step();
      reset_n = 1'b1; reset_n_fp = 1'b1;
      m0_req = 1'b1; m0_addr = 16'h0010; pready = 1'b1; prdata = 16'h1111;
      step(3);
      nvec++; if ({f_m0_done, m0_done} !== 2'b11) begin nerr++; $display("FAIL fp_warmup: got %b want 11", {f_m0_done, m0_done}); end
      m0_req = 1'b0;
      step();
      m0_addr = 16'h0100; m1_addr = 16'h0200; m0_req = 1'b1; m1_req = 1'b1;
      step();
      nvec++; if ({f_grant_id, grant_id} !== 2'b01) begin nerr++; $display("FAIL fp_vs_rr_grant: got fp/rr %b want 01", {f_grant_id, grant_id}); end
      step(2);
      nvec++; if ({f_m0_done, f_m1_done} !== 2'b10) begin nerr++; $display("FAIL fp_done1: got %b want 10", {f_m0_done, f_m1_done}); end
      m0_req = 1'b0; m1_req = 1'b0;
      step();
      m0_req = 1'b1; m1_req = 1'b1;
      step();
      nvec++; if ({f_psel, f_grant_id, f_paddr} !== {2'b10, 16'h0100}) begin nerr++; $display("FAIL fp_grant_again: got %b %h want 10 0100", {f_psel, f_grant_id}, f_paddr); end
      step(2);
      nvec++; if (f_m0_done !== 1'b1) begin nerr++; $display("FAIL fp_done2: got %b want 1", f_m0_done); end
      m0_req = 1'b0;
      step();
      nvec++; if ({f_psel, f_grant_id, f_paddr} !== {2'b11, 16'h0200}) begin nerr++; $display("FAIL fp_m1_after_drop: got %b %h want 11 0200", {f_psel, f_grant_id}, f_paddr); end
      step(2);
      nvec++; if ({f_m1_done, f_m1_err} !== 2'b10) begin nerr++; $display("FAIL fp_m1_done: got %b want 10", {f_m1_done, f_m1_err}); end
      m1_req = 1'b0;
      step();
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout;
      m1_req = 1'b1; m1_addr = 16'h0300; m1_write = 1'b0; pready = 1'b0; prdata = 16'h4321;
      step(2);
      step(7);
      nvec++; if ({psel, penable, m1_done} !== 3'b110) begin nerr++; $display("FAIL to_still_waiting: got %b want 110", {psel, penable, m1_done}); end
      step();
      nvec++; if ({m1_done, m1_err, psel, penable} !== 4'b1100) begin nerr++; $display("FAIL to_abort: got %b want 1100", {m1_done, m1_err, psel, penable}); end
      nvec++; if (m1_rdata !== 16'hDEAD) begin nerr++; $display("FAIL to_rdata: got %h want dead", m1_rdata); end
      m1_req = 1'b0;
      step();
      m1_req = 1'b1; pready = 1'b1; prdata = 16'h7777;
      step(3);
      nvec++; if ({m1_done, m1_err, m1_rdata} !== {2'b10, 16'h7777}) begin nerr++; $display("FAIL to_recover: got %b %h want 10 7777", {m1_done, m1_err}, m1_rdata); end
      m1_req = 1'b0;
      step();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_reset_mid_access();
      test_single_read();
      test_write_wait();
      test_rr_contention();
      test_fixed_priority();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
